// File: rtl/pipelined_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_tree
// Description : Pipelined multi-operand adder tree with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder_tree #(
    parameter int SIZE        = 5,
    parameter int DATA_WIDTH  = 4,
    parameter int SIGNED_MODE = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [SIZE*DATA_WIDTH-1:0]             inputs,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH+$clog2(SIZE)-1:0]     out_sum
);

    localparam int LEVELS    = $clog2(SIZE);
    localparam int STAGES    = (LEVELS > 1) ? LEVELS : 1;
    localparam bit SX        = (SIGNED_MODE != 0);

    function automatic int node_count(input int lvl);
        return (SIZE + (1 << lvl) - 1) >> lvl;
    endfunction

    logic              en;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;

    assign out_valid = vld_q[STAGES-1];
    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;

    // Clear only kills valid bits; data registers are don't-care without them.
    always_comb begin
        vld_d = vld_q;
        if (clear) begin
            vld_d = '0;
        end else if (en) begin
            vld_d = (vld_q << 1) | STAGES'(in_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    generate
        if (LEVELS == 0) begin : g_single
            logic [DATA_WIDTH-1:0] data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (en) begin
                    data_q <= inputs;
                end
            end

            assign out_sum = data_q;
        end else begin : g_tree
            for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
                localparam int W_IN = DATA_WIDTH + k - 1;
                localparam int W    = DATA_WIDTH + k;
                localparam int M    = node_count(k - 1);
                localparam int C    = node_count(k);

                logic [M*W_IN-1:0] prev;
                logic [C*W-1:0]    data_d;
                logic [C*W-1:0]    data_q;

                if (k == 1) begin : g_src_in
                    assign prev = inputs;
                end else begin : g_src_lvl
                    assign prev = g_lvl[k-1].data_q;
                end

                // Odd leftover operand is extended and added to zero (pass-through).
                for (genvar j = 0; j < C; j++) begin : g_node
                    logic [W-1:0] a;
                    logic [W-1:0] b;

                    assign a = {prev[(2*j+1)*W_IN-1] & SX, prev[2*j*W_IN +: W_IN]};
                    if (2*j + 1 < M) begin : g_add
                        assign b = {prev[(2*j+2)*W_IN-1] & SX, prev[(2*j+1)*W_IN +: W_IN]};
                    end else begin : g_pass
                        assign b = '0;
                    end
                    assign data_d[j*W +: W] = a + b;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_q <= '0;
                    end else if (en) begin
                        data_q <= data_d;
                    end
                end
            end

            assign out_sum = g_lvl[LEVELS].data_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder_tree
// Description : Scoreboard bench for four configurations of the adder tree.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder_tree;

    typedef struct {
        int          d;
        logic [31:0] v;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  ops [8];
    logic [19:0] in_u;
    logic [31:0] in_8;
    logic [7:0]  in_1;

    logic        ir0, ir1, ir2, ir3;
    logic        ov0, ov1, ov2, ov3;
    logic [6:0]  sum0, sum1, sum3;
    logic [7:0]  sum2;

    ent_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    // DUT 0: 5x4 unsigned, DUT 1: 5x4 signed, DUT 2: 1x8, DUT 3: 8x4 unsigned
    pipelined_adder_tree #(.SIZE(5), .DATA_WIDTH(4), .SIGNED_MODE(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir0),
        .inputs(in_u), .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0));
    pipelined_adder_tree #(.SIZE(5), .DATA_WIDTH(4), .SIGNED_MODE(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir1),
        .inputs(in_u), .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1));
    pipelined_adder_tree #(.SIZE(1), .DATA_WIDTH(8), .SIGNED_MODE(0)) u_one (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
        .inputs(in_1), .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2));
    pipelined_adder_tree #(.SIZE(8), .DATA_WIDTH(4), .SIGNED_MODE(0)) u_eight (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir3),
        .inputs(in_8), .out_valid(ov3), .out_ready(out_ready), .out_sum(sum3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_u = '0;
        in_8 = '0;
        for (int i = 0; i < 5; i++) in_u[i*4 +: 4] = ops[i][3:0];
        for (int i = 0; i < 8; i++) in_8[i*4 +: 4] = ops[i][3:0];
        in_1 = ops[0];
    end

    function automatic logic get_ov(input int d);
        case (d)
            0:       return ov0;
            1:       return ov1;
            2:       return ov2;
            default: return ov3;
        endcase
    endfunction

    function automatic logic get_ir(input int d);
        case (d)
            0:       return ir0;
            1:       return ir1;
            2:       return ir2;
            default: return ir3;
        endcase
    endfunction

    function automatic logic [31:0] get_os(input int d);
        case (d)
            0:       return {25'd0, sum0};
            1:       return {25'd0, sum1};
            2:       return {24'd0, sum2};
            default: return {25'd0, sum3};
        endcase
    endfunction

    function automatic logic [31:0] model(input int d);
        int s;
        int t;
        int w;
        s = 0;
        w = 7;
        case (d)
            0: for (int i = 0; i < 5; i++) s += int'(ops[i][3:0]);
            1: for (int i = 0; i < 5; i++) begin
                   t = $signed(ops[i][3:0]);
                   s += t;
               end
            2: begin s = int'(ops[0]); w = 8; end
            default: for (int i = 0; i < 8; i++) s += int'(ops[i][3:0]);
        endcase
        return 32'(s & ((1 << w) - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input int d);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].d == d) idx = i;
        end
        chk($sformatf("expected_entry_dut%0d", d), 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
            chk($sformatf("sum_dut%0d", d), get_os(d), sb[idx].v);
            sb.delete(idx);
        end
    endtask

    // Outputs leaving at the coming edge are retired before clear/reset flush the rest.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (get_ov(d) && out_ready) pop_check(d);
            end
            if (clear) begin
                sb.delete();
            end else if (in_valid) begin
                for (int d = 0; d < 4; d++) begin
                    if (get_ir(d)) sb.push_back('{d, model(d)});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 8; i++) ops[i] = v;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_all(8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ov0), 32'd0);
        chk("rst_sum", get_os(0), 32'd0);
        chk("rst_sum_size8", get_os(3), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(ir0), 32'd1);
        tick();

        // Full-scale pulse: latency 3 for SIZE 5/8, 1 for SIZE 1
        set_all(8'h0F);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("latency_size5", 32'(ov0), 32'(c == 3));
            chk("latency_size1", 32'(ov2), 32'(c == 1));
            chk("latency_size8", 32'(ov3), 32'(c == 3));
        end
        tick();

        // Signed minimum, then mixed-sign operands
        set_all(8'h08);
        in_valid = 1'b1;
        tick();
        ops = '{8'h07, 8'h01, 8'h0F, 8'h02, 8'h0E, 8'h00, 8'h00, 8'h00};
        tick();
        in_valid = 1'b0;
        repeat (4) tick();

        // Streaming four back-to-back vectors
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_all(8'h00);
                1: begin set_all(8'h00); ops[0] = 8'h01; end
                2: set_all(8'h0F);
                default: begin set_all(8'h00); ops[0] = 8'h0A; end
            endcase
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_ready", 32'(ir0), 32'd1);
            if (i == 3) chk("stream_first_out", 32'(ov0), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stream_out", 32'(ov0), 32'(c < 3));
        end
        repeat (2) tick();

        // Backpressure with three vectors in flight
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin set_all(8'h00); ops[0] = 8'h03; end
                1: set_all(8'h02);
                default: begin set_all(8'h00); ops[0] = 8'h0F; ops[1] = 8'h0F; end
            endcase
            in_valid = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(ov0), 32'd1);
            chk("stall_sum", get_os(0), 32'd3);
            chk("stall_ready", 32'(ir0), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_drain", 32'(ov0), 32'(c < 3));
        end
        tick();

        // Clear one cycle after two accepts, with a competing input vector
        set_all(8'h00); ops[0] = 8'h05;
        in_valid = 1'b1;
        tick();
        ops[0] = 8'h06;
        tick();
        ops[0] = 8'h09;
        clear  = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("clear_no_out", 32'(ov0), 32'd0);
            chk("clear_no_out_size1", 32'(ov2), 32'd0);
        end
        tick();

        // Asynchronous reset mid-stream, then a fresh vector
        for (int i = 0; i < 3; i++) begin
            set_all(8'(i + 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_arst_valid", 32'(ov0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov0), 32'd0);
        chk("arst_sum", get_os(0), 32'd0);
        chk("arst_ready", 32'(ir0), 32'd1);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        set_all(8'h09);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
- Parametrised, pipelined multi-operand adder. Sums SIZE operands of DATA_WIDTH bits each into a full-width result with no truncation.
- Has one register stage per tree level and a valid/ready handshake on both sides, so it accepts one operand vector per cycle.
- Successor to the combinational balanced/unbalanced adder trees. Adds pipelining, backpressure, a signed mode and a synchronous clear.
- Sits between operand producers (e.g. partial-product generators) and the multiplier result path.

Parameters:
- SIZE, 5: number of operands; legal range 1..64.
- DATA_WIDTH, 4: width of each operand in bits; legal range 1..32.
- SIGNED_MODE, 0: 0 = operands unsigned and zero-extended; 1 = operands two's complement and sign-extended.
- Derived localparam LEVELS = $clog2(SIZE).
- Derived localparam STAGES = max(LEVELS,1).
- Derived localparam OUT_WIDTH = DATA_WIDTH + LEVELS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush of all in-flight data.
- in_valid  input  1  the operand vector on inputs is valid.
- in_ready  output  1  the block can accept a vector this cycle.
- inputs  input  SIZE*DATA_WIDTH  operand i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- out_valid  output  1  out_sum holds a valid result.
- out_ready  input  1  the downstream consumer accepts the result.
- out_sum  output  OUT_WIDTH  sum of all operands, full width.

Behaviour:
- Reset: while rst_n = 0, all stage valid bits are 0 and all data registers are 0. Therefore out_valid = 0 and out_sum = 0 during and after reset. in_ready = 1 immediately after release.
- Pipeline enable: en = out_ready | ~out_valid. in_ready = en, combinational from out_ready and the last-stage valid only; it has no path from in_valid.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Stage advance: when en = 1, every stage loads from its predecessor, including its valid bit. Stage 1 loads {in_valid, level-1 partial sums}, so bubbles propagate as valid = 0. When en = 0, all stages hold.
- Latency: a vector accepted at edge N produces out_valid at edge N+STAGES-1, i.e. visible STAGES cycles after acceptance, when there is no stall.
- Throughput: 1 vector per cycle while out_ready = 1.
- Tree structure:
  - Level k takes the M operands of level k-1 and adds adjacent pairs (2j, 2j+1) into ceil(M/2) results.
  - When M is odd, the highest-index operand passes through registered without an add.
  - Each level's results are 1 bit wider than its inputs, extended according to SIGNED_MODE.
  - Level LEVELS yields exactly one value of OUT_WIDTH bits.
  - Overflow is impossible by construction.
- SIZE = 1: LEVELS = 0, STAGES = 1. A single register stage; out_sum is the extended operand with OUT_WIDTH = DATA_WIDTH.
- SIZE a power of two: the tree is perfectly balanced; no pass-through registers.
- Stall stability: while out_valid = 1 and out_ready = 0, out_sum and out_valid hold stable and in_ready = 0. No result is lost or duplicated.
- clear:
  - At the rising edge with clear = 1, all valid bits go to 0; data registers may keep their values.
  - clear has priority over a simultaneous input transfer, and that vector is dropped.
  - in_ready is unaffected by clear.
- Reset mid-operation: asserting rst_n = 0 asynchronously discards all in-flight vectors. Outputs go to their reset values without waiting for a clock edge.
- Simultaneous input and output transfer with a full pipeline: both occur and occupancy is unchanged.

Test Plan:
- Unsigned full scale (SIZE=5, DATA_WIDTH=4, SIGNED_MODE=0): all operands 15, in_valid pulse, out_ready = 1 -> out_valid exactly 3 cycles later with out_sum = 75 (7'h4B); out_valid lasts one cycle.
- Signed minimum (SIGNED_MODE=1): all operands 4'h8 (-8) -> out_sum = 7'h58 (-40). Then operands {1,-1,2,-2,7}, with operand 0 = 7 -> out_sum = 7.
- Streaming: 4 back-to-back vectors with sums 0, 1, 75, 10 -> 4 consecutive out_valid cycles, in order, with those values; in_ready stays 1.
- Backpressure: out_ready = 0 for 3 cycles while 3 vectors are in flight -> out_sum holds its first value, in_ready = 0 while the stall persists, no vector lost. After release, all 3 emerge in order on consecutive cycles.
- Clear and reset: clear asserted one cycle after 2 accepts -> no out_valid follows. rst_n pulled low mid-stream -> out_valid = 0 and out_sum = 0 immediately; the next vector after release produces a correct sum.
- Corner sizes: SIZE=1, DATA_WIDTH=8, operand 200 -> out_sum = 200 after 1 cycle. SIZE=8, all operands 15 -> out_sum = 120 after 3 cycles.
